// File: rtl/pipelined_control_unit_pkg.sv
// rtl/pipelined_control_unit_pkg.sv - shared types, encodings and opcode decode for the pipelined control unit
package pipelined_control_unit_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_B    = 4'd1,
    OP_BEQ  = 4'd2,
    OP_BLT  = 4'd3,
    OP_LDW  = 4'd4,
    OP_LDB  = 4'd5,
    OP_STW  = 4'd6,
    OP_STB  = 4'd7,
    OP_ADD  = 4'd8,
    OP_ADDI = 4'd9,
    OP_SUB  = 4'd10,
    OP_DIV  = 4'd11,
    OP_SHL  = 4'd12
  } opcode_e;

  // First opcode value that is not a defined instruction.
  localparam logic [31:0] OPCODE_LIMIT = 32'd13;

  localparam logic [1:0] BR_ALWAYS = 2'b00;
  localparam logic [1:0] BR_EQ     = 2'b01;
  localparam logic [1:0] BR_LT     = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_DIV = 2'b10;
  localparam logic [1:0] ALU_SHL = 2'b11;

  typedef struct packed {
    logic       valid;
    logic       branch;
    logic [1:0] br_cond;
    logic       a1_sel;
    logic       rf_we;
    logic [1:0] ext_sel;
    logic       alu_b_sel;
    logic [1:0] alu_ctl;
    logic       set_flags;
    logic       mem_we;
    logic       mem_re;
    logic       byte_en;
    logic       is_div;
    logic       wb_sel;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NOP = '0;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_e;

  // Control word for a legal opcode; the valid bit is set, the caller gates it.
  function automatic ctrl_word_t decode(input logic [3:0] op);
    ctrl_word_t w;
    w       = CTRL_NOP;
    w.valid = 1'b1;
    case (opcode_e'(op))
      OP_NOP: ;
      OP_B, OP_BEQ, OP_BLT: begin
        w.branch    = 1'b1;
        w.a1_sel    = 1'b1;
        w.ext_sel   = 2'b01;
        w.alu_b_sel = 1'b1;
        w.set_flags = 1'b1;
        w.br_cond   = (opcode_e'(op) == OP_BEQ) ? BR_EQ :
                      (opcode_e'(op) == OP_BLT) ? BR_LT : BR_ALWAYS;
      end
      OP_LDW, OP_LDB: begin
        w.rf_we   = 1'b1;
        w.mem_re  = 1'b1;
        w.wb_sel  = 1'b1;
        w.byte_en = (opcode_e'(op) == OP_LDB);
      end
      OP_STW, OP_STB: begin
        w.mem_we  = 1'b1;
        w.byte_en = (opcode_e'(op) == OP_STB);
      end
      OP_ADD: begin
        w.rf_we   = 1'b1;
        w.alu_ctl = ALU_ADD;
      end
      OP_ADDI: begin
        w.rf_we     = 1'b1;
        w.ext_sel   = 2'b01;
        w.alu_b_sel = 1'b1;
      end
      OP_SUB: begin
        w.rf_we   = 1'b1;
        w.alu_ctl = ALU_SUB;
      end
      OP_DIV: begin
        w.rf_we   = 1'b1;
        w.alu_ctl = ALU_DIV;
        w.is_div  = 1'b1;
      end
      OP_SHL: begin
        w.rf_we   = 1'b1;
        w.alu_ctl = ALU_SHL;
      end
      default: w = CTRL_NOP;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/pipelined_control_unit_if.sv
// rtl/pipelined_control_unit_if.sv - decode/pipeline control bundle between the core and the control unit
// slave  (control unit): in opcode_d, valid_d, flush_ex, mem_ready;
//                        out stall_fd, ex_ctrl, mem_ctrl, wb_ctrl, mem_req, illegal_op
//                        [+ retired_cnt, stall_cnt, flush_cnt when CTRL_PERF_CNT_EN]
// master (core side):    the mirror image of slave
interface pipelined_control_unit_if #(
  parameter int OPCODE_W = 4
`ifdef CTRL_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
);
  import pipelined_control_unit_pkg::*;

  logic [OPCODE_W-1:0] opcode_d;
  logic                valid_d;
  logic                flush_ex;
  logic                mem_ready;
  logic                stall_fd;
  ctrl_word_t          ex_ctrl;
  ctrl_word_t          mem_ctrl;
  ctrl_word_t          wb_ctrl;
  logic                mem_req;
  logic                illegal_op;
`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0]    retired_cnt;
  logic [CNT_W-1:0]    stall_cnt;
  logic [CNT_W-1:0]    flush_cnt;
`endif

  modport slave (
    input  opcode_d, valid_d, flush_ex, mem_ready,
`ifdef CTRL_PERF_CNT_EN
    output retired_cnt, stall_cnt, flush_cnt,
`endif
    output stall_fd, ex_ctrl, mem_ctrl, wb_ctrl, mem_req, illegal_op
  );

  modport master (
    output opcode_d, valid_d, flush_ex, mem_ready,
`ifdef CTRL_PERF_CNT_EN
    input  retired_cnt, stall_cnt, flush_cnt,
`endif
    input  stall_fd, ex_ctrl, mem_ctrl, wb_ctrl, mem_req, illegal_op
  );

endinterface

// File: rtl/pipelined_control_unit_decoder.sv
// rtl/pipelined_control_unit_decoder.sv - combinational opcode decoder for the ID stage
// in  opcode  : instruction opcode (OPCODE_W bits)
// in  valid   : decode slot holds a live, unsquashed instruction
// out ctrl    : control word, CTRL_NOP when not valid or illegal
// out illegal : valid instruction with an undefined opcode
module pipelined_control_unit_decoder
  import pipelined_control_unit_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                valid,
  output ctrl_word_t          ctrl,
  output logic                illegal
);

  logic out_of_range;

  assign out_of_range = (32'(opcode) >= OPCODE_LIMIT);

  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = valid & out_of_range;
    if (valid && !out_of_range) begin
      ctrl = decode(4'(opcode));
    end
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - ID/EX/MEM/WB control pipeline with divide and memory stalls and branch flush
// in  clk, rst   : core clock, synchronous active-high reset
// bus (slave)    : opcode_d/valid_d from decode, flush_ex from branch resolve, mem_ready from data memory;
//                  stall_fd, per-stage control words, mem_req and illegal_op back to the core.
// Optional CTRL_PERF_CNT_EN adds retired_cnt, stall_cnt and flush_cnt on the bus.
module pipelined_control_unit
  import pipelined_control_unit_pkg::*;
#(
  parameter int OPCODE_W   = 4,
  parameter int DIV_CYCLES = 8
`ifdef CTRL_PERF_CNT_EN
  , parameter int CNT_W    = 32
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  pipelined_control_unit_if.slave   bus
);

  // Counter holds the number of further stall cycles after the BUSY entry cycle.
  localparam int DCNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES - 1) : 1;
  localparam logic [DCNT_W-1:0] DIV_LOAD = (DIV_CYCLES > 2) ? DCNT_W'(DIV_CYCLES - 2) : '0;
  localparam bit DIV_MULTI = (DIV_CYCLES > 1);

  ctrl_word_t id_word;
  ctrl_word_t ex_q, mem_q, wb_q;
  logic       dec_valid, dec_illegal, illegal_q;
  logic       mem_req, mem_stall, div_stall, ex_is_div;

  div_state_e        state_q, state_d;
  logic [DCNT_W-1:0] cnt_q, cnt_d;

  assign dec_valid = bus.valid_d & ~bus.flush_ex;

  pipelined_control_unit_decoder #(
    .OPCODE_W (OPCODE_W)
  ) u_decoder (
    .opcode  (bus.opcode_d),
    .valid   (dec_valid),
    .ctrl    (id_word),
    .illegal (dec_illegal)
  );

  assign mem_req   = mem_q.valid & (mem_q.mem_we | mem_q.mem_re);
  assign mem_stall = mem_req & ~bus.mem_ready;
  assign ex_is_div = ex_q.valid & ex_q.is_div;

  // Divide sequencer. The entry cycle already stalls, so a DIV spends
  // DIV_CYCLES non-memory-stalled cycles in EX; the last one releases EX.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_stall = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (ex_is_div && DIV_MULTI) begin
          div_stall = 1'b1;
          if (!mem_stall && !bus.flush_ex) begin
            state_d = DIV_BUSY;
            cnt_d   = DIV_LOAD;
          end
        end
      end
      DIV_BUSY: begin
        div_stall = 1'b1;
        if (!mem_stall) begin
          if (bus.flush_ex) begin
            // EX is being replaced, so the divide cannot continue.
            state_d = DIV_IDLE;
          end else if (cnt_q == '0) begin
            state_d   = DIV_IDLE;
            div_stall = 1'b0;
          end else begin
            cnt_d = cnt_q - DCNT_W'(1);
          end
        end
      end
      default: begin
        state_d = DIV_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stage registers: memory stall freezes everything (a pending flush is
  // re-asserted by the branch still sitting in EX), a flush squashes the
  // decode slot, a divide stall holds EX and drops a bubble into MEM.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= CTRL_NOP;
      mem_q     <= CTRL_NOP;
      wb_q      <= CTRL_NOP;
      illegal_q <= 1'b0;
    end else if (mem_stall) begin
      illegal_q <= 1'b0;
    end else if (bus.flush_ex) begin
      ex_q      <= id_word;
      mem_q     <= ex_q;
      wb_q      <= mem_q;
      illegal_q <= 1'b0;
    end else if (div_stall) begin
      mem_q     <= CTRL_NOP;
      wb_q      <= mem_q;
      illegal_q <= 1'b0;
    end else begin
      ex_q      <= id_word;
      mem_q     <= ex_q;
      wb_q      <= mem_q;
      illegal_q <= dec_illegal;
    end
  end

  assign bus.stall_fd   = mem_stall | div_stall;
  assign bus.ex_ctrl    = ex_q;
  assign bus.mem_ctrl   = mem_q;
  assign bus.wb_ctrl    = wb_q;
  assign bus.mem_req    = mem_req;
  assign bus.illegal_op = illegal_q;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] retired_q, stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      if (wb_q.valid && !mem_stall) begin
        retired_q <= retired_q + CNT_W'(1);
      end
      if (mem_stall || div_stall) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (bus.flush_ex && !mem_stall) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign bus.retired_cnt = retired_q;
  assign bus.stall_cnt   = stall_q;
  assign bus.flush_cnt   = flush_q;
`endif

endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb/tb_pipelined_control_unit.sv - scoreboard bench for pipelined_control_unit
module tb_pipelined_control_unit;
  import pipelined_control_unit_pkg::*;

  localparam int DIVC = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_control_unit_if #(.OPCODE_W(4)) bus ();

  pipelined_control_unit #(
    .OPCODE_W   (4),
    .DIV_CYCLES (DIVC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       stall_fd;
    logic       mem_req;
    logic       illegal;
    ctrl_word_t ex;
    ctrl_word_t mem;
    logic       wb_valid;
  } cyc_exp_t;

  cyc_exp_t   cyc_q[$];
  ctrl_word_t ret_q[$];
  int checks   = 0;
  int failures = 0;
  logic mon_en    = 1'b0;
  logic prev_hold = 1'b0;
  cyc_exp_t mon_e;

  // Reference model: each stage holds the opcode it carries, -1 for a bubble.
  int   m_ex  = -1;
  int   m_mem = -1;
  int   m_wb  = -1;
  int   m_age = 0;   // non-memory-stalled cycles the EX instruction has spent in EX
  logic m_ill = 1'b0;

  function automatic ctrl_word_t mw(input int op);
    ctrl_word_t w;
    w = '0;
    if (op < 0 || op > 12) return w;
    w.valid = 1'b1;
    if (op >= 1 && op <= 3) begin
      w.branch    = 1'b1;
      w.br_cond   = 2'(op - 1);
      w.a1_sel    = 1'b1;
      w.ext_sel   = 2'b01;
      w.alu_b_sel = 1'b1;
      w.set_flags = 1'b1;
    end
    if (op == 4 || op == 5) begin
      w.rf_we   = 1'b1;
      w.mem_re  = 1'b1;
      w.wb_sel  = 1'b1;
      w.byte_en = (op == 5);
    end
    if (op == 6 || op == 7) begin
      w.mem_we  = 1'b1;
      w.byte_en = (op == 7);
    end
    if (op == 9) begin
      w.rf_we     = 1'b1;
      w.ext_sel   = 2'b01;
      w.alu_b_sel = 1'b1;
    end
    if (op == 8 || op >= 10) begin
      w.rf_we = 1'b1;
      case (op)
        10:      w.alu_ctl = 2'd1;
        11:      w.alu_ctl = 2'd2;
        12:      w.alu_ctl = 2'd3;
        default: w.alu_ctl = 2'd0;
      endcase
      w.is_div = (op == 11);
    end
    return w;
  endfunction

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%b exp=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_word(input string name, input ctrl_word_t act, input ctrl_word_t exp);
    logic bad;
    checks++;
    bad = exp.valid ? (act !== exp) : (act.valid !== 1'b0);
    if (bad) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, record expected outputs, advance the model.
  task automatic step(input logic r, input int op, input logic vd, input logic fl,
                      input logic mr, output logic consumed);
    cyc_exp_t e;
    logic mreq, mstall, dstall;
    rst           = r;
    bus.opcode_d  = 4'(op);
    bus.valid_d   = vd;
    bus.flush_ex  = fl;
    bus.mem_ready = mr;

    mreq   = (m_mem >= 4 && m_mem <= 7);
    mstall = mreq && !mr;
    dstall = (m_ex == 11) && (m_age + 1 < DIVC);
    e.stall_fd = mstall | dstall;
    e.mem_req  = mreq;
    e.illegal  = m_ill;
    e.ex       = mw(m_ex);
    e.mem      = mw(m_mem);
    e.wb_valid = (m_wb >= 0);
    cyc_q.push_back(e);

    consumed = 1'b0;
    if (r) begin
      // Words still in EX/MEM are abandoned; they are the newest entries.
      if (m_ex >= 0 && ret_q.size() > 0) void'(ret_q.pop_back());
      if (m_mem >= 0 && ret_q.size() > 0) void'(ret_q.pop_back());
      m_ex = -1; m_mem = -1; m_wb = -1; m_age = 0; m_ill = 1'b0;
      consumed = 1'b1;
    end else if (mstall) begin
      m_ill = 1'b0;
    end else if (fl) begin
      m_wb = m_mem; m_mem = m_ex; m_ex = -1; m_age = 0; m_ill = 1'b0;
      consumed = 1'b1;
    end else if (dstall) begin
      m_wb = m_mem; m_mem = -1; m_age++; m_ill = 1'b0;
    end else begin
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = (vd && op <= 12) ? op : -1;
      m_ill = vd && (op > 12);
      m_age = 0;
      if (m_ex >= 0) ret_q.push_back(mw(m_ex));
      consumed = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int op);
    logic c;
    int   n;
    c = 1'b0;
    n = 0;
    while (!c && n < 100) begin
      step(1'b0, op, 1'b1, 1'b0, 1'b1, c);
      n++;
    end
    if (!c) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout op=%0d", op);
    end
  endtask

  task automatic idle(input int n, input logic mr);
    logic c;
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, mr, c);
  endtask

  // Monitor: per-cycle outputs against the cycle queue, and every word
  // freshly arriving in WB against the retirement queue.
  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      mon_e = cyc_q.pop_front();
      chk_bit("stall_fd", bus.stall_fd, mon_e.stall_fd);
      chk_bit("mem_req", bus.mem_req, mon_e.mem_req);
      chk_bit("illegal_op", bus.illegal_op, mon_e.illegal);
      chk_word("ex_ctrl", bus.ex_ctrl, mon_e.ex);
      chk_word("mem_ctrl", bus.mem_ctrl, mon_e.mem);
      chk_bit("wb_valid", bus.wb_ctrl.valid, mon_e.wb_valid);
    end
    if (mon_en) begin
      if (bus.wb_ctrl.valid === 1'b1 && !prev_hold) begin
        if (ret_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wb_retire unexpected act=%h exp=none", bus.wb_ctrl);
        end else begin
          chk_word("wb_retire", bus.wb_ctrl, ret_q.pop_front());
        end
      end
      prev_hold = bus.mem_req & ~bus.mem_ready;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic c;
    int   cur_op;
    logic cur_v, fl, mr, r;

    rst           = 1'b1;
    bus.opcode_d  = '0;
    bus.valid_d   = 1'b0;
    bus.flush_ex  = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Held in reset with live-looking inputs: everything must stay 0.
    step(1'b1, 14, 1'b1, 1'b0, 1'b0, c);
    step(1'b1, 11, 1'b1, 1'b0, 1'b1, c);

    issue(8);                          // ADD
    idle(4, 1'b1);
    issue(11); issue(8);               // DIV then ADD
    idle(12, 1'b1);
    issue(4);                          // LDW with a 3-cycle wait
    idle(1, 1'b1);
    idle(3, 1'b0);
    idle(4, 1'b1);
    issue(2);                          // BEQ taken, SUB squashed
    step(1'b0, 10, 1'b1, 1'b1, 1'b1, c);
    idle(4, 1'b1);
    issue(14);                         // illegal opcode
    idle(3, 1'b1);
    issue(7); issue(11);               // STB held in MEM while DIV waits in EX
    idle(3, 1'b0);
    idle(12, 1'b1);
    issue(11);                         // reset in the middle of a divide
    idle(3, 1'b1);
    step(1'b1, 0, 1'b0, 1'b0, 1'b1, c);
    step(1'b1, 0, 1'b0, 1'b0, 1'b1, c);
    idle(3, 1'b1);

    c = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (c) begin
        cur_op = ($urandom_range(0, 7) == 0) ? $urandom_range(13, 15) : $urandom_range(0, 12);
        cur_v  = ($urandom_range(0, 3) != 0);
      end
      fl = (m_ex >= 1 && m_ex <= 3) && ($urandom_range(0, 1) == 1);
      mr = ($urandom_range(0, 2) != 0);
      r  = ($urandom_range(0, 199) == 0);
      step(r, cur_op, cur_v, fl, mr, c);
    end

    idle(20, 1'b1);
    @(negedge clk);
    #1;
    chk_bit("ret_q_drained", (ret_q.size() == 0), 1'b1);
    chk_bit("cyc_q_drained", (cyc_q.size() == 0), 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
